// File: rtl/layer_sequencer.sv
// layer_sequencer: drives the input -> hidden -> output_softmax layer chain.
// Runs the forward pass one layer at a time and forms the softmax /
// cross-entropy output delta. In training runs it then sweeps the weight
// addresses of every weighted layer, walking from the last layer back to layer 1.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; outputs idle
// S_FWD   | forward pass; layer_q is enabled for LAYER_LATENCY cycles
// S_DELTA | one cycle; output delta is registered at the end of the cycle
// S_UPD   | weight update, layer_q from NUM_LAYERS-1 down to 1, addr_q sweeps
// S_DONE  | one-cycle done pulse, then back to idle
module layer_sequencer #(
  parameter int MAX_NUM_NEURONS = 4,
  parameter int NUM_LAYERS      = 4,
  parameter int LAYER_LATENCY   = 8,
  localparam int AW = (MAX_NUM_NEURONS > 1) ? $clog2(MAX_NUM_NEURONS) : 1,
  localparam int DW = 32 * MAX_NUM_NEURONS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  train,
  input  logic [AW-1:0]         label,
  input  logic [DW-1:0]         output_sofmax_layer,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            layer_state,
  output logic [NUM_LAYERS-1:0] enable_layers,
  output logic [AW-1:0]         weight_memory_address,
  output logic [DW-1:0]         deltafunction
);

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CW = (LAYER_LATENCY > 1) ? $clog2(LAYER_LATENCY) : 1;

  localparam logic [CW-1:0] LAST_CNT   = CW'(LAYER_LATENCY - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(MAX_NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_DELTA,
    S_UPD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  train_q, train_d;
  logic [AW-1:0]         label_q, label_d;
  logic [DW-1:0]         delta_q, delta_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            ls_q, ls_d;
  logic [NUM_LAYERS-1:0] en_q, en_d;

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      train_q <= 1'b0;
      label_q <= '0;
      delta_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ls_q    <= 2'b00;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      train_q <= train_d;
      label_q <= label_d;
      delta_q <= delta_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ls_q    <= ls_d;
      en_q    <= en_d;
    end
  end

  // Next-state, counters and delta; outputs are decoded from the next state
  // so every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    train_d = train_q;
    label_d = label_q;
    delta_d = delta_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FWD;
          layer_d = '0;
          cnt_d   = '0;
          train_d = train;
          label_d = label;
        end
      end
      S_FWD: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (layer_q == LAST_LAYER) begin
            // layer_q stays at the last layer, which is where the update sweep begins
            state_d = train_q ? S_DELTA : S_DONE;
            if (!train_q) layer_d = '0;
          end else begin
            layer_d = layer_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DELTA: begin
        for (int k = 0; k < MAX_NUM_NEURONS; k++) begin
          if (int'(label_q) == k)
            delta_d[32*k +: 32] = output_sofmax_layer[32*k +: 32] - 32'h0001_0000;
          else
            delta_d[32*k +: 32] = output_sofmax_layer[32*k +: 32];
        end
        addr_d = '0;
        if (NUM_LAYERS > 1) begin
          state_d = S_UPD;
          layer_d = LAST_LAYER;
        end else begin
          state_d = S_DONE;
          layer_d = '0;
        end
      end
      S_UPD: begin
        if (addr_q == LAST_ADDR) begin
          addr_d = '0;
          if (layer_q == LW'(1)) begin
            state_d = S_DONE;
            layer_d = '0;
          end else begin
            layer_d = layer_q - 1'b1;
          end
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        layer_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        layer_d = '0;
        cnt_d   = '0;
        addr_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    unique case (state_d)
      S_FWD:   ls_d = 2'b01;
      S_UPD:   ls_d = 2'b10;
      S_DELTA: ls_d = 2'b11;
      default: ls_d = 2'b00;
    endcase
    if (state_d == S_FWD || state_d == S_UPD)
      en_d = NUM_LAYERS'(1) << layer_d;
    else
      en_d = '0;
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign layer_state           = ls_q;
  assign enable_layers         = en_q;
  assign weight_memory_address = addr_q;
  assign deltafunction         = delta_q;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Top-level training/inference sequencer for the input -> hidden -> output_softmax layer chain. It pulses one layer at a time through the forward pass and forms the softmax/cross-entropy output delta from the target label. In training mode it then walks the weight-update pass backwards through the weighted layers, stepping the shared weight_memory_address. It drives enable_layers, layer_state, weight_memory_address and deltafunction for the layer instances.

Parameters:
MAX_NUM_NEURONS, 4, lanes per layer bus (32 bits per lane); also the number of weight addresses swept per layer
NUM_LAYERS, 4, number of layers; layer 0 is the input layer and has no weights
LAYER_LATENCY, 8, cycles each layer stays enabled during the forward pass (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle request to begin a run; sampled only in IDLE
train  input  1  sampled with start: 1 = forward+delta+update, 0 = forward only
label  input  clog2(MAX_NUM_NEURONS)  target class, sampled with start
output_sofmax_layer  input  32*MAX_NUM_NEURONS  softmax activations, lane k = bits [32k+31:32k], Q16.16
busy  output  1  high from the cycle after start is accepted until DONE is left
done  output  1  one-cycle pulse at end of run
layer_state  output  2  00 idle, 01 forward, 10 update, 11 delta
enable_layers  output  NUM_LAYERS  one-hot layer enable, 0 when idle
weight_memory_address  output  clog2(MAX_NUM_NEURONS)  weight index under update
deltafunction  output  32*MAX_NUM_NEURONS  output-layer delta, Q16.16 two's complement

Behaviour:
- Reset, sampled at a clock edge, has priority over everything and forces IDLE from any state, including mid-run. Reset values: busy=0, done=0, layer_state=00, enable_layers=0, weight_memory_address=0, deltafunction=0, internal counters=0, latched train/label=0.
- States: IDLE, FWD, DELTA, UPD, DONE.
- IDLE: outputs idle. start=1 latches train and label; the next cycle is FWD with layer index 0 and cycle counter 0.
- start is ignored in every state other than IDLE. There is no queueing.
- FWD: layer_state=01 and enable_layers has only bit[layer] set.
  - The counter runs from 0 to LAYER_LATENCY-1. On the last count, layer advances.
  - After the last count of layer NUM_LAYERS-1: go to DELTA if train=1, otherwise go to DONE.
- DELTA (one cycle): layer_state=11, enable_layers=0.
  - At the end of the cycle each lane k registers delta_k = a_k - 0x00010000 if k==label, else a_k.
  - Arithmetic is 32-bit wrapping two's complement.
  - A label with no matching lane gives delta = a on every lane.
  - deltafunction holds its value until the next DELTA or reset.
- UPD: layer_state=10. Layer index starts at NUM_LAYERS-1 and counts down to 1; layer 0 is never updated.
  - For each layer, weight_memory_address steps 0,1,...,MAX_NUM_NEURONS-1, one value per cycle.
  - After the last address the address wraps to 0 and the layer decrements.
  - After layer 1 at the last address, go to DONE.
- DONE (one cycle): done=1, busy=1, layer_state=00, enable_layers=0. Next state is IDLE. A start in this cycle is ignored.
- busy is 1 in FWD, DELTA, UPD and DONE.
- weight_memory_address is 0 outside UPD.
- Latency, with start accepted in cycle 0:
  - FWD occupies cycles 1..NUM_LAYERS*LAYER_LATENCY.
  - With train=0, done is in cycle NUM_LAYERS*LAYER_LATENCY+1 (33 at defaults).
  - With train=1, done is in cycle NUM_LAYERS*LAYER_LATENCY + 2 + (NUM_LAYERS-1)*MAX_NUM_NEURONS (46 at defaults).
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset, then start=1 with train=0 for one cycle -> enable_layers is 0001 for cycles 1-8, 0010 for 9-16, 0100 for 17-24, 1000 for 25-32, with layer_state=01 throughout. done pulses in cycle 33 only. busy=1 in cycles 1-33. deltafunction stays 0.
- start with train=1, label=2; lanes a0..a3 = 0x00004000, 0x00002000, 0x00008000, 0x00002000 -> DELTA in cycle 33 with layer_state=11. Afterwards deltafunction lanes = 0x00004000, 0x00002000, 0xFFFF8000, 0x00002000.
- Same train run -> in cycles 34-45 enable_layers is 1000, 0100, 0010 for four cycles each, with address 0,1,2,3 repeating and layer_state=10. done in cycle 46. enable_layers never equals 0001 during UPD.
- start pulsed in cycles 5, 20 and 40 of a train run, plus in the DONE cycle -> no effect on the sequence. A start one cycle after DONE (IDLE) is accepted.
- reset asserted in cycle 38 of a train run -> at the next edge all outputs hold reset values, including deltafunction=0. A subsequent start with train=0 runs a clean 33-cycle inference.
- LAYER_LATENCY=1, NUM_LAYERS=2, train=1 -> FWD occupies cycles 1-2, DELTA cycle 3, UPD cycles 4-7 (layer 1 only, addresses 0-3), done in cycle 8.
